// File: rtl/pg_pkg.sv
// rtl/pg_pkg.sv - shared types, domain map and sizing helper for the power-gate sequencer
package pg_pkg;

    typedef enum logic [1:0] {
        PG_ON   = 2'd0,
        PG_ISO  = 2'd1,
        PG_OFF  = 2'd2,
        PG_WAKE = 2'd3
    } pg_state_t;

    localparam int PG_FETCH_BASE    = 0;
    localparam int PG_DISPATCH_BASE = 4;
    localparam int PG_ISSUE_BASE    = 8;
    localparam int PG_EXEC_BASE     = 13;
    localparam int PG_SALU_BASE     = 18;
    localparam int PG_CALU_BASE     = 23;
    localparam int PG_COMMIT_BASE   = 28;
    localparam int PG_RF_BASE       = 32;
    localparam int PG_AL_BASE       = 36;
    localparam int PG_LSQ_BASE      = 40;
    localparam int PG_IQ_BASE       = 42;
    localparam int PG_IBUFF_BASE    = 46;
    localparam int PG_NUM_DOMAINS   = 50;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int pg_cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pg_domain_fsm.sv
// rtl/pg_domain_fsm.sv - one gated domain: ON/ISO/OFF/WAKE sequencing with dwell counter
module pg_domain_fsm
    import pg_pkg::*;
#(
    parameter int ISO_CYCLES  = 2,
    parameter int WAKE_CYCLES = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      target,
    input  logic      grant,
    output pg_state_t state,
    output logic      pwr_en,
    output logic      iso_en
);

    localparam int CW = (pg_cw(ISO_CYCLES) > pg_cw(WAKE_CYCLES)) ? pg_cw(ISO_CYCLES)
                                                                 : pg_cw(WAKE_CYCLES);
    localparam logic [CW-1:0] ISO_LOAD  = CW'(ISO_CYCLES - 1);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);

    pg_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PG_ON;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            PG_ON: begin
                if (!target) begin
                    state_d = PG_ISO;
                    cnt_d   = ISO_LOAD;
                end
            end
            PG_ISO: begin
                // Power is still applied here, so a returning target can abort safely.
                if (target) begin
                    state_d = PG_ON;
                end else if (cnt_q == '0) begin
                    state_d = PG_OFF;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PG_OFF: begin
                if (target && grant) begin
                    state_d = PG_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            PG_WAKE: begin
                if (cnt_q == '0) begin
                    state_d = PG_ON;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = PG_ON;
        endcase
    end

    assign state  = state_q;
    assign pwr_en = (state_q != PG_OFF);
    assign iso_en = (state_q != PG_ON);

endmodule

// File: rtl/power_gate_sequencer.sv
// rtl/power_gate_sequencer.sv - per-domain power/isolation sequencing with staggered wake-up
// Optional stall counter enabled by defining PG_STALL_CNT_EN.
module power_gate_sequencer
    import pg_pkg::*;
#(
    parameter int NUM_DOMAINS    = PG_NUM_DOMAINS,
    parameter int ISO_CYCLES     = 2,
    parameter int WAKE_CYCLES    = 4,
    parameter int STAGGER_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DOMAINS-1:0] domainActive_i,
    input  logic                   cfgLoad_i,
    output logic [NUM_DOMAINS-1:0] pwrEn_o,
    output logic [NUM_DOMAINS-1:0] isoEn_o,
    output logic                   stable_o,
    output logic                   holdPipe_o,
    output logic [31:0]            stallCycles_o
);

    localparam int SW = pg_cw(STAGGER_CYCLES);

    logic [NUM_DOMAINS-1:0] target_q;
    logic [NUM_DOMAINS-1:0] off_req;
    logic [NUM_DOMAINS-1:0] settled;
    logic [NUM_DOMAINS-1:0] grant;
    logic [SW-1:0]          stagger_q;
    logic                   stable_q;
    pg_state_t              dom_state [NUM_DOMAINS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= '1;
        end else if (cfgLoad_i) begin
            target_q <= domainActive_i;
        end
    end

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        pg_domain_fsm #(
            .ISO_CYCLES  (ISO_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_fsm (
            .clk    (clk),
            .reset  (reset),
            .target (target_q[i]),
            .grant  (grant[i]),
            .state  (dom_state[i]),
            .pwr_en (pwrEn_o[i]),
            .iso_en (isoEn_o[i])
        );

        assign off_req[i] = (dom_state[i] == PG_OFF) && target_q[i];
        assign settled[i] = ((dom_state[i] == PG_ON)  &&  target_q[i]) ||
                            ((dom_state[i] == PG_OFF) && !target_q[i]);
    end

    // Isolate the lowest set request bit; only one wake may start per stagger window.
    assign grant = (stagger_q == '0) ? (off_req & (~off_req + NUM_DOMAINS'(1)))
                                     : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stagger_q <= '0;
        end else if (|grant) begin
            stagger_q <= SW'(STAGGER_CYCLES - 1);
        end else if (stagger_q != '0) begin
            stagger_q <= stagger_q - SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= 1'b1;
        end else begin
            stable_q <= (&settled) && !cfgLoad_i;
        end
    end

    assign stable_o   = stable_q;
    assign holdPipe_o = ~stable_q;

`ifdef PG_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!stable_q) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stallCycles_o = stall_q;
`else
    assign stallCycles_o = '0;
`endif

endmodule
